// File: rtl/api_ctrl.sv
// SPI-mode-0 frame engine: pops TX FIFO words, shifts them out MSB-first,
// captures MISO into the RX FIFO and closes every frame with a load strobe and an idle gap.
module api_ctrl #(
   parameter int TXCNT_W     = 10,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst,
   output logic               txfifo_pop,
   input  logic [31:0]        txfifo_dout,
   input  logic [TXCNT_W-1:0] txcnt,
   output logic               rxfifo_push,
   output logic [31:0]        rxfifo_din,
   input  logic               rxfull,
   input  logic               reg_flush,
   input  logic [27:0]        reg_timeout,
   input  logic [7:0]         reg_sck,
   input  logic [7:0]         reg_word_num,
   output logic [2:0]         reg_state,
   output logic               spi_sck,
   output logic               spi_mosi,
   input  logic               spi_miso,
   output logic               spi_load
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_POP   = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_SHIFT = 3'd3;
   localparam logic [2:0] S_LATCH = 3'd4;
   localparam logic [2:0] S_WAIT  = 3'd5;

   localparam int CW = (TXCNT_W > 8) ? TXCNT_W : 8;

   logic [2:0]             state;
   logic [7:0]             div;
   logic [5:0]             bit_cnt;
   logic [7:0]             word_cnt;
   logic [27:0]            wait_cnt;
   logic [31:0]            tx_shift;
   logic [31:0]            rx_shift;
   logic                   sck;
   logic [SYNC_STAGES-1:0] miso_pipe;
   logic                   miso_sync;
   logic                   div_tc;
   logic                   start_ok;
   logic                   wait_done;
   logic [7:0]             word_cnt_nxt;

   assign miso_sync    = miso_pipe[SYNC_STAGES-1];
   // >= rather than == so a shrinking reg_sck cannot strand the divider
   assign div_tc       = (div >= reg_sck);
   assign start_ok     = !reg_flush && (reg_word_num != 8'd0) &&
                         (CW'(txcnt) >= CW'(reg_word_num));
   assign word_cnt_nxt = word_cnt + 8'd1;
   assign wait_done    = ({1'b0, wait_cnt} + 29'd1) >= {1'b0, reg_timeout};

   // Strobes decode straight from state flops so reset clears them without a glitch
   assign reg_state  = state;
   assign txfifo_pop = (state == S_POP);
   assign spi_load   = (state == S_LATCH);
   assign spi_sck    = sck;
   assign spi_mosi   = (state == S_SHIFT) & tx_shift[31];

   // MISO synchronizer chain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         miso_pipe <= {SYNC_STAGES{1'b0}};
      end else begin
         miso_pipe[0] <= spi_miso;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            miso_pipe[i] <= miso_pipe[i-1];
         end
      end
   end

   // Frame sequencer, SCK divider and shift registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         div         <= 8'd0;
         bit_cnt     <= 6'd0;
         word_cnt    <= 8'd0;
         wait_cnt    <= 28'd0;
         tx_shift    <= 32'd0;
         rx_shift    <= 32'd0;
         sck         <= 1'b0;
         rxfifo_push <= 1'b0;
         rxfifo_din  <= 32'd0;
      end else if (reg_flush) begin
         state       <= S_IDLE;
         div         <= 8'd0;
         bit_cnt     <= 6'd0;
         word_cnt    <= 8'd0;
         wait_cnt    <= 28'd0;
         tx_shift    <= 32'd0;
         rx_shift    <= 32'd0;
         sck         <= 1'b0;
         rxfifo_push <= 1'b0;
      end else begin
         rxfifo_push <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_ok) begin
                  word_cnt <= 8'd0;
                  state    <= S_POP;
               end
            end
            S_POP: begin
               state <= S_LOAD;
            end
            S_LOAD: begin
               tx_shift <= txfifo_dout;
               bit_cnt  <= 6'd0;
               div      <= 8'd0;
               sck      <= 1'b0;
               state    <= S_SHIFT;
            end
            S_SHIFT: begin
               if (div_tc) begin
                  div <= 8'd0;
                  sck <= ~sck;
                  if (!sck) begin
                     rx_shift <= {rx_shift[30:0], miso_sync};
                  end else begin
                     tx_shift <= {tx_shift[30:0], 1'b0};
                     bit_cnt  <= bit_cnt + 6'd1;
                     if (bit_cnt == 6'd31) begin
                        // Full word is already in rx_shift; a full RX FIFO drops it without stalling
                        rxfifo_din  <= rx_shift;
                        rxfifo_push <= ~rxfull;
                        word_cnt    <= word_cnt_nxt;
                        state       <= (word_cnt_nxt == reg_word_num) ? S_LATCH : S_POP;
                     end
                  end
               end else begin
                  div <= div + 8'd1;
               end
            end
            S_LATCH: begin
               if (div_tc) begin
                  div      <= 8'd0;
                  wait_cnt <= 28'd0;
                  state    <= S_WAIT;
               end else begin
                  div <= div + 8'd1;
               end
            end
            S_WAIT: begin
               if (wait_done) begin
                  state <= S_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 28'd1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
